// File: rtl/oram_path_fetch_if.sv
// Request, response and bucket-memory bundle of the ORAM path fetch engine.
// slave is the engine's view, master is the requester/memory side.
interface oram_path_fetch_if #(
  parameter int A = 8,
  parameter int D = 6,
  parameter int K = 3
);
  localparam int TW = 3 + (D - 1) + D + 8 * A;

  logic                 req_valid;
  logic                 req_ready;
  logic [D-1:0]         req_block;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [8*A-1:0]       rsp_val;
  logic [D-1:0]         rsp_block;
  logic [D-2:0]         rsp_new_pos;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [D-1:0]         mem_addr;
  logic [K*TW-1:0]      mem_rd_data;
  logic [K*TW-1:0]      mem_wr_data;

  modport slave (
    input  req_valid, req_block, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_hit, rsp_val,
    output rsp_block, rsp_new_pos,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );

  modport master (
    output req_valid, req_block, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_hit, rsp_val,
    input  rsp_block, rsp_new_pos,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/oram_path_fetch.sv
// Tree-ORAM path fetch: position map lookup, full path walk, remap.
// Define ORAM_FETCH_STATS_EN to add saturating hit/miss counters.
module oram_path_fetch #(
  parameter int          A         = 8,
  parameter int          D         = 6,
  parameter int          K         = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic              clk,
  input logic              rst_n,
  oram_path_fetch_if.slave bus
`ifdef ORAM_FETCH_STATS_EN
  ,
  output logic [15:0]      stat_hits,
  output logic [15:0]      stat_misses
`endif
);
  localparam int TW = 3 + (D - 1) + D + 8 * A;
  localparam int VW = 8 * A;
  localparam int LW = $clog2(D);
  localparam int NB = 2 ** D;
  localparam int PO = TW - 3;
  localparam int BO = TW - 2 - D;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RD, CMP, WR, REMAP, RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [D-1:0]    blk;
  logic [D-2:0]    walk_pos;
  logic [LW-1:0]   level;
  logic [D-1:0]    node;
  logic [D-1:0]    node_nx;
  logic            hit;
  logic [VW-1:0]   val_q;
  logic [K*TW-1:0] wr_data;
  logic [15:0]     lfsr;
  logic            pmap_v [NB];
  logic [D-2:0]    pmap_p [NB];
  logic            rsp_valid;
  logic            rsp_hit;
  logic [VW-1:0]   rsp_val;
  logic [D-1:0]    rsp_block;
  logic [D-2:0]    rsp_new_pos;

  logic            m_any;
  int              m_idx;
  logic [VW-1:0]   m_val;
  logic            m_vv;
  logic [TW-1:0]   t;
  logic [K*TW-1:0] wd;
  logic            last;
  logic            take;
  logic            adv;

  assign last    = (level == LW'(D - 1));
  assign take    = (state == CMP) && !hit && m_any;
  assign adv     = ((state == CMP) && !take) || (state == WR);
  assign node_nx = (node << 1) + {{(D-1){1'b0}}, 1'b1}
                 + {{(D-1){1'b0}}, walk_pos[level]};

  // lowest-index matching tuple of the bucket on the read bus
  always_comb begin
    t     = '0;
    m_any = 1'b0;
    m_idx = 0;
    m_val = '0;
    m_vv  = 1'b0;
    for (int j = K - 1; j >= 0; j--) begin
      t = bus.mem_rd_data[j*TW +: TW];
      if (t[TW-1] && t[TW-2] &&
          t[PO -: D-1] == walk_pos && t[BO -: D] == blk) begin
        m_any = 1'b1;
        m_idx = j;
        m_val = t[VW-1:0];
        m_vv  = t[VW];
      end
    end
    wd = bus.mem_rd_data;
    for (int j = 0; j < K; j++)
      if (j == m_idx) wd[j*TW + TW - 1] = 1'b0;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_nx = LOOKUP;
      LOOKUP:  state_nx = RD;
      RD:      state_nx = CMP;
      CMP:     state_nx = take ? WR : (last ? REMAP : RD);
      WR:      state_nx = last ? REMAP : RD;
      REMAP:   state_nx = RESP;
      RESP:    if (rsp_valid && bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from the current state and held registers
  always_comb begin
    bus.req_ready   = (state == IDLE);
    bus.mem_rd_en   = (state == RD);
    bus.mem_wr_en   = (state == WR);
    bus.mem_addr    = node;
    bus.mem_wr_data = wr_data;
    bus.rsp_valid   = rsp_valid;
    bus.rsp_hit     = rsp_hit;
    bus.rsp_val     = rsp_val;
    bus.rsp_block   = rsp_block;
    bus.rsp_new_pos = rsp_new_pos;
  end

  // walk datapath, position map and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk         <= '0;
      walk_pos    <= '0;
      level       <= '0;
      node        <= '0;
      hit         <= 1'b0;
      val_q       <= '0;
      wr_data     <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_val     <= '0;
      rsp_block   <= '0;
      rsp_new_pos <= '0;
      for (int i = 0; i < NB; i++) begin
        pmap_v[i] <= 1'b0;
        pmap_p[i] <= '0;
      end
    end else begin
      if (state == IDLE && bus.req_valid) begin
        blk   <= bus.req_block;
        hit   <= 1'b0;
        val_q <= '0;
      end
      if (state == LOOKUP) begin
        level <= '0;
        node  <= '0;
        if (pmap_v[blk]) begin
          walk_pos <= pmap_p[blk];
        end else begin
          walk_pos    <= lfsr[D-2:0];
          pmap_v[blk] <= 1'b1;
          pmap_p[blk] <= lfsr[D-2:0];
        end
      end
      if (take) begin
        hit     <= 1'b1;
        val_q   <= m_vv ? m_val : '0;
        wr_data <= wd;
      end
      if (adv && !last) begin
        node  <= node_nx;
        level <= level + 1'b1;
      end
      if (state == REMAP) begin
        pmap_v[blk] <= 1'b1;
        pmap_p[blk] <= lfsr[D-2:0];
        rsp_hit     <= hit;
        rsp_val     <= val_q;
        rsp_block   <= blk;
        rsp_new_pos <= lfsr[D-2:0];
      end
      if (state == RESP && !rsp_valid)
        rsp_valid <= 1'b1;
      else if (rsp_valid && bus.rsp_ready)
        rsp_valid <= 1'b0;
    end
  end

  // free-running Galois LFSR, taps 0xB400
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
  end

`ifdef ORAM_FETCH_STATS_EN
  // saturating hit/miss counters, bumped on response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (rsp_valid && bus.rsp_ready) begin
      if (rsp_hit) begin
        if (stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
      end else begin
        if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_oram_path_fetch.sv
// Bench for oram_path_fetch: random requests, bucket memory model,
// and a scoreboard fed by a tuple-level reference of the tree.
module tb_oram_path_fetch;
  localparam int A  = 8;
  localparam int D  = 6;
  localparam int K  = 3;
  localparam int TW = 3 + (D - 1) + D + 8 * A;
  localparam int KW = K * TW;
  localparam int VW = 8 * A;
  localparam int NN = 2 ** D - 1;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic          en;
    logic          pv;
    logic [D-2:0]  pos;
    logic [D-1:0]  bn;
    logic          vv;
    logic [VW-1:0] val;
  } tup_t;

  typedef struct {
    bit           hit;
    logic [VW-1:0] val;
    logic [D-1:0] blk;
    logic [D-2:0] np;
    int           t;
    int           lat;
  } exp_rsp_t;

  typedef struct {
    bit            wr;
    int            addr;
    logic [KW-1:0] data;
  } mem_ev_t;

  typedef struct {
    int            n;
    logic [KW-1:0] d;
  } poke_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oram_path_fetch_if #(.A(A), .D(D), .K(K)) bus ();

`ifdef ORAM_FETCH_STATS_EN
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;
`endif

  oram_path_fetch #(.A(A), .D(D), .K(K), .LFSR_SEED(SEED)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef ORAM_FETCH_STATS_EN
    ,
    .stat_hits(stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int ecnt = 0;
  int m_hits = 0;
  int m_miss = 0;
  bit hold = 1'b0;
  bit active = 1'b0;
  logic [15:0] m_lfsr;
  exp_rsp_t cur;
  exp_rsp_t exp_rsp_q[$];
  mem_ev_t exp_mem_q[$];
  poke_t poke_q[$];
  logic [KW-1:0] ext_mem [64] = '{default: '0};
  logic [KW-1:0] ref_mem [64] = '{default: '0};
  bit ref_pv [64] = '{default: 1'b0};
  logic [D-2:0] ref_pos [64] = '{default: '0};

  task automatic chk(string nm, logic [255:0] a, logic [255:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  function automatic logic [15:0] lstep(logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int path_node(logic [D-2:0] p, int lvl);
    int n = 0;
    for (int i = 0; i < lvl; i++) n = 2 * n + 1 + int'(p[i]);
    return n;
  endfunction

  function automatic logic [TW-1:0] mk(logic en, logic pv,
      logic [D-2:0] p, logic [D-1:0] b, logic vv, logic [VW-1:0] v);
    tup_t t;
    t = '{en: en, pv: pv, pos: p, bn: b, vv: vv, val: v};
    return t;
  endfunction

  always @(posedge clk) ecnt <= ecnt + 1;

  // reference LFSR, stepped once per clock like the spec requires
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else m_lfsr <= lstep(m_lfsr);
  end

  always @(posedge clk) begin
    #1;
    bus.rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // external bucket memory: one-cycle read latency
  always @(posedge clk) begin
    poke_t p;
    if (bus.mem_wr_en) ext_mem[bus.mem_addr] = bus.mem_wr_data;
    bus.mem_rd_data <= ext_mem[bus.mem_addr];
    while (poke_q.size() > 0) begin
      p = poke_q.pop_front();
      ext_mem[p.n] = p.d;
    end
  end

  // monitor: memory strobes and responses against the scoreboard
  always @(negedge clk) begin
    mem_ev_t e;
    if (rst_n) begin
      if (bus.mem_rd_en || bus.mem_wr_en) begin
        chk("mem_exclusive", bus.mem_rd_en && bus.mem_wr_en, 0);
        if (exp_mem_q.size() == 0) begin
          chk("mem_unexpected", 1, 0);
        end else begin
          e = exp_mem_q.pop_front();
          chk("mem_kind", bus.mem_wr_en, e.wr);
          chk("mem_addr", bus.mem_addr, e.addr);
          if (e.wr) chk("mem_wr_data", bus.mem_wr_data, e.data);
        end
      end
      if (bus.rsp_valid) begin
        if (!active) begin
          if (exp_rsp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
            cur = '{bus.rsp_hit, bus.rsp_val, bus.rsp_block,
                    bus.rsp_new_pos, ecnt, 0};
          end else begin
            cur = exp_rsp_q.pop_front();
            chk("rsp_latency", ecnt - cur.t, cur.lat);
          end
          active = 1'b1;
        end
        chk("rsp_hit", bus.rsp_hit, cur.hit);
        chk("rsp_val", bus.rsp_val, cur.val);
        chk("rsp_block", bus.rsp_block, cur.blk);
        chk("rsp_new_pos", bus.rsp_new_pos, cur.np);
        if (bus.rsp_ready) active = 1'b0;
      end
    end
  end

  task automatic plant(int n, int j, logic [TW-1:0] t);
    ref_mem[n][j*TW +: TW] = t;
    poke_q.push_back('{n, ref_mem[n]});
  endtask

  // drive one request and push the reference model's expectations
  task automatic issue(logic [D-1:0] b);
    int k;
    int n;
    int tt;
    bit hit;
    logic [VW-1:0] val;
    logic [D-2:0] pos;
    logic [15:0] look;
    logic [15:0] nl;
    tup_t t;
    k = 0;
    while (!bus.req_ready && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("issue_ready_timeout", k >= 300, 0);
    bus.req_valid = 1'b1;
    bus.req_block = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    look = m_lfsr;
    tt = ecnt;
    pos = ref_pv[b] ? ref_pos[b] : look[D-2:0];
    hit = 1'b0;
    val = '0;
    for (int lvl = 0; lvl < D; lvl++) begin
      n = path_node(pos, lvl);
      exp_mem_q.push_back('{1'b0, n, '0});
      for (int j = 0; j < K; j++) begin
        t = ref_mem[n][j*TW +: TW];
        if (!hit && t.en && t.pv && t.pos == pos && t.bn == b) begin
          hit = 1'b1;
          val = t.vv ? t.val : '0;
          t.en = 1'b0;
          ref_mem[n][j*TW +: TW] = t;
          exp_mem_q.push_back('{1'b1, n, ref_mem[n]});
        end
      end
    end
    nl = look;
    repeat (2 * D + 1 + int'(hit)) nl = lstep(nl);
    exp_rsp_q.push_back('{hit, val, b, nl[D-2:0], tt,
                          2 * D + 3 + int'(hit)});
    ref_pv[b] = 1'b1;
    ref_pos[b] = nl[D-2:0];
    if (hit) m_hits++;
    else m_miss++;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 400; k++) begin
      if (exp_rsp_q.size() == 0 && !active) break;
      @(posedge clk);
      #1;
    end
    chk("rsp_timeout", k >= 400, 0);
  endtask

  task automatic check_reset();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_hit", bus.rsp_hit, 0);
    chk("rst_rsp_val", bus.rsp_val, 0);
    chk("rst_rsp_block", bus.rsp_block, 0);
    chk("rst_rsp_new_pos", bus.rsp_new_pos, 0);
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_mem_wr_en", bus.mem_wr_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wr_data", bus.mem_wr_data, 0);
`ifdef ORAM_FETCH_STATS_EN
    chk("rst_stat_hits", stat_hits, 0);
    chk("rst_stat_misses", stat_misses, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int n;
    int bad;
    logic [D-2:0] p;
    bus.req_valid = 1'b0;
    bus.req_block = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // cold miss on an empty tree
    issue(6'd5);
    wait_done();

    // hit at level 3 of block 9's path
    issue(6'd9);
    wait_done();
    p = ref_pos[9];
    plant(path_node(p, 3), 2, mk(1'b1, 1'b1, p, 6'd9, 1'b1,
          64'h0123456789ABCDEF));
    issue(6'd9);
    wait_done();

    // duplicate tuples at levels 1 and 4: only level 1 invalidated
    issue(6'd20);
    wait_done();
    p = ref_pos[20];
    plant(path_node(p, 1), 0, mk(1'b1, 1'b1, p, 6'd20, 1'b1, 64'h11));
    plant(path_node(p, 4), 1, mk(1'b1, 1'b1, p, 6'd20, 1'b1, 64'h44));
    issue(6'd20);
    wait_done();

    // back-pressure with a dropped second request
    hold = 1'b1;
    issue(6'd9);
    b = 0;
    while (!bus.rsp_valid && b < 100) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("bp_rsp_seen", bus.rsp_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_req_ready", bus.req_ready, 0);
    bus.req_valid = 1'b1;
    bus.req_block = 6'd33;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_still_valid", bus.rsp_valid, 1);
    hold = 1'b0;
    wait_done();
    repeat (30) @(posedge clk);
    #1;
    chk("bp_no_extra_mem", exp_mem_q.size(), 0);
    chk("bp_idle", bus.req_ready, 1);

    // random traffic with planted and noise tuples
    for (int it = 0; it < 40; it++) begin
      b = $urandom_range(0, 62);
      if (ref_pv[b] && $urandom_range(0, 1) == 1) begin
        n = path_node(ref_pos[b], $urandom_range(0, D - 1));
        plant(n, $urandom_range(0, K - 1),
              mk(1'b1, 1'b1, ref_pos[b], 6'(b), 1'($urandom),
                 {$urandom, $urandom}));
      end
      if ($urandom_range(0, 2) == 0) begin
        plant($urandom_range(0, NN - 1), $urandom_range(0, K - 1),
              mk(1'($urandom), 1'($urandom), 5'($urandom),
                 6'($urandom_range(0, 62)), 1'($urandom),
                 {$urandom, $urandom}));
      end
      issue(6'(b));
      wait_done();
    end

    bad = 0;
    for (int i = 0; i < NN; i++)
      if (ext_mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);

    // reset during level-2 compare of a miss walk
    issue(6'd63);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_rsp_q.delete();
    exp_mem_q.delete();
    active = 1'b0;
    foreach (ref_pv[i]) ref_pv[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
    check_reset();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(6'd63);
    wait_done();

    // three misses then two hits after the reset
    for (int i = 0; i < 3; i++) begin
      issue(6'(40 + i));
      wait_done();
    end
    for (int i = 0; i < 2; i++) begin
      p = ref_pos[40 + i];
      plant(path_node(p, 2), 0, mk(1'b1, 1'b1, p, 6'(40 + i), 1'b0,
            64'hDEAD));
      issue(6'(40 + i));
      wait_done();
    end
    repeat (3) @(posedge clk);
    #1;
`ifdef ORAM_FETCH_STATS_EN
    chk("stat_hits", stat_hits, m_hits);
    chk("stat_misses", stat_misses, m_miss);
`endif
    chk("end_no_pending", exp_mem_q.size() + exp_rsp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
